// File: rtl/reg_mux_n.sv
// Registered N-channel mux with valid/ready on every channel and a single output stage.
// Define REG_MUX_RR_EN to add the round-robin auto-select mode (mode = 1).
module reg_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0] grant_fix;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] hs_p0;
    logic                load;
    logic                xfer_p0;
    logic [WIDTH-1:0]    data_p0;
    logic [SEL_W-1:0]    idx_p0;
    logic [WIDTH-1:0]    data_p1;
    logic                vld_p1;

    // An out-of-range sel matches no channel, so the mux simply stalls.
    always_comb begin
        grant_fix = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant_fix[k] = (sel == SEL_W'(k));
        end
    end

`ifdef REG_MUX_RR_EN
    logic [SEL_W-1:0]    last;
    logic [CHANNELS-1:0] grant_rr;
    int                  dist;
    int                  best;

    // Distance from last+1 (mod CHANNELS); the nearest valid channel wins, last itself ranks lowest.
    always_comb begin
        grant_rr = '0;
        best     = CHANNELS;
        dist     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            dist = (k + CHANNELS - 1 - int'(last)) % CHANNELS;
            if (in_valid[k] && (dist < best)) begin
                best        = dist;
                grant_rr    = '0;
                grant_rr[k] = 1'b1;
            end
        end
    end

    assign grant = mode ? grant_rr : grant_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= SEL_W'(CHANNELS - 1);
        end else if (xfer_p0 && mode) begin
            last <= idx_p0;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign grant       = grant_fix;
`endif

    assign load     = !vld_p1 || out_ready;
    assign in_ready = grant & {CHANNELS{load && rst_n}};
    assign hs_p0    = in_valid & in_ready;
    assign xfer_p0  = |hs_p0;

    always_comb begin
        data_p0 = '0;
        idx_p0  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (hs_p0[k]) begin
                data_p0 = in_data[k*WIDTH +: WIDTH];
                idx_p0  = SEL_W'(k);
            end
        end
    end

    // p0 -> p1: output register, refilled on transfer, emptied on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (xfer_p0) begin
            data_p1 <= data_p0;
            vld_p1  <= 1'b1;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_reg_mux_n.sv
// Scoreboard bench for reg_mux_n: directed vectors push expected words, a monitor pops on output handshakes.
module tb_reg_mux_n;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [1:0]      sel;
    logic            mode;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;

    logic [3*W-1:0]  in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [1:0]      sel3;
    logic            mode3;
    logic [W-1:0]    out_data3;
    logic            out_valid3;
    logic            out_ready3;

    int              n_cmp = 0;
    int              n_bad = 0;
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    mon_exp;
    logic [3:0]      fair_rdy[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0]      fair_dat[6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

    reg_mux_n #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    reg_mux_n #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_word: got %02h, no word expected", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL out_word: got %02h, expected %02h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;

        in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid = '1; sel = 2'd2; out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 4'b0000);
        rst_n = 1'b1;
        #1 chk("release_in_ready", in_ready, 4'b0100);
        exp_q.push_back(8'hC2);
        tick();
        chk("first_out_data", out_data, 8'hC2);
        chk("first_out_valid", out_valid, 1);
        in_valid = '0;
        tick();
        chk("drain_out_valid", out_valid, 0);

        sel = 2'd1; in_data[W +: W] = 8'hA5; in_valid = 4'b0010; out_ready = 1'b0;
        #1 chk("bp_load_ready", in_ready, 4'b0010);
        exp_q.push_back(8'hA5);
        tick();
        in_data[W +: W] = 8'h5A;
        repeat (3) begin
            #1;
            chk("bp_hold_data", out_data, 8'hA5);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 4'b0000);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_refill_ready", in_ready, 4'b0010);
        exp_q.push_back(8'h5A);
        tick();
        chk("bp_refill_data", out_data, 8'h5A);
        chk("bp_refill_valid", out_valid, 1);
        in_valid = '0;
        tick();
        chk("bp_drain_valid", out_valid, 0);

        in_data3 = {8'h99, 8'h77, 8'h55}; in_valid3 = 3'b111; sel3 = 2'd3;
        repeat (3) begin
            #1 chk("oor_in_ready", in_ready3, 3'b000);
            tick();
            chk("oor_out_valid", out_valid3, 0);
        end
        sel3 = 2'd1;
        #1 chk("oor_recover_ready", in_ready3, 3'b010);
        tick();
        chk("oor_recover_data", out_data3, 8'h77);
        chk("oor_recover_valid", out_valid3, 1);
        in_valid3 = '0;

`ifdef REG_MUX_RR_EN
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_data = {8'd3, 8'd2, 8'd1, 8'd0}; out_ready = 1'b1; mode = 1'b1; sel = 2'd0;
        in_valid = 4'b0100;
        #1 chk("rr_skip_ready", in_ready, 4'b0100);
        exp_q.push_back(8'd2);
        tick();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        #1 chk("sw_fixed_ready", in_ready, 4'b0001);
        exp_q.push_back(8'd0);
        tick();
        mode = 1'b1;
        #1 chk("sw_back_rr_ready", in_ready, 4'b1000);
        exp_q.push_back(8'd3);
        tick();
        in_valid = 4'b0010;
        #1 chk("rr_wrap_ready", in_ready, 4'b0010);
        exp_q.push_back(8'd1);
        tick();
        in_valid = '0;
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr_fair_ready", in_ready, fair_rdy[i]);
            exp_q.push_back(fair_dat[i]);
            tick();
        end
        in_valid = '0;
        tick();
`else
        mode = 1'b1; sel = 2'd3; in_valid = 4'b1111; in_data[3*W +: W] = 8'h3C; out_ready = 1'b1;
        #1 chk("mode_ignored_ready", in_ready, 4'b1000);
        exp_q.push_back(8'h3C);
        tick();
        in_valid = '0;
        tick();
`endif

        mode = 1'b0; sel = 2'd1; in_data[W +: W] = 8'hEE; in_valid = 4'b0010; out_ready = 1'b0;
        tick();
        in_valid = 4'b1111;
        #1 chk("mid_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_ready", in_ready, 4'b0000);
        in_valid = '0;
        tick();
        rst_n = 1'b1;
`ifdef REG_MUX_RR_EN
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1 chk("post_rst_rr_ready", in_ready, 4'b0001);
        exp_q.push_back(8'd0);
        tick();
        in_valid = '0;
        tick();
`endif
        repeat (2) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
